// File: rtl/turnstile_ctrl.sv
// Turnstile controller: card read, fare deduction, remaining-balance display and gate release.
// All outputs are registered from the next state, so they change on the same edge as the state.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for an armed card; display 8/B
//   READ   | card must stay present READ_TICKS cycles; display 8/8
//   CHECK  | one cycle: fare check, write-back strobe if affordable; 8/8
//   SHOW   | remaining balance as two BCD digits for SHOW_TICKS cycles
//   OPEN   | gate released until a passage or OPEN_TICKS cycles; F/0
//   REJECT | insufficient balance code A/0 for SHOW_TICKS cycles

module turnstile_ctrl #(
  parameter int BAL_W      = 8,
  parameter int FARE       = 5,
  parameter int READ_TICKS = 400,
  parameter int SHOW_TICKS = 600,
  parameter int OPEN_TICKS = 800,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_present,
  input  logic [BAL_W-1:0] card_bal,
  input  logic             pass_sensor,
  output logic [BAL_W-1:0] new_bal,
  output logic             new_bal_valid,
  output logic [3:0]       disp_hi,
  output logic [3:0]       disp_lo,
  output logic             gate_open,
  output logic [CNT_W-1:0] pass_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_CHECK  = 3'd2,
    S_SHOW   = 3'd3,
    S_OPEN   = 3'd4,
    S_REJECT = 3'd5
  } state_t;

  localparam int MAX_RS = (READ_TICKS > SHOW_TICKS) ? READ_TICKS : SHOW_TICKS;
  localparam int MAX_T  = (MAX_RS > OPEN_TICKS) ? MAX_RS : OPEN_TICKS;
  localparam int TICK_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int EXT_W  = (BAL_W > 7) ? BAL_W : 7;

  localparam logic [BAL_W-1:0]  FARE_B    = BAL_W'(FARE);
  localparam logic [TICK_W-1:0] READ_LAST = TICK_W'(READ_TICKS - 1);
  localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0] OPEN_LAST = TICK_W'(OPEN_TICKS - 1);

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               arm_q, arm_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [BAL_W-1:0]   new_bal_q, new_bal_d;
  logic               nbv_q, nbv_d;
  logic [3:0]         disp_hi_q, disp_hi_d;
  logic [3:0]         disp_lo_q, disp_lo_d;
  logic               gate_q, gate_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [BAL_W-1:0]   rem;
  logic [EXT_W-1:0]   rem_ext, rem_clamp;
  logic [3:0]         rem_tens, rem_units;

  // Remainder shown in SHOW; bal_q is stable from the CHECK cycle until the next read.
  always_comb begin
    rem       = bal_q - FARE_B;
    rem_ext   = EXT_W'(rem);
    rem_clamp = (rem_ext > EXT_W'(99)) ? EXT_W'(99) : rem_ext;
    rem_tens  = 4'(rem_clamp / EXT_W'(10));
    rem_units = 4'(rem_clamp % EXT_W'(10));
  end

  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    case (state_q)
      S_IDLE:   if (card_present && arm_q) state_d = S_READ;
      S_READ: begin
        if (!card_present) begin
          state_d = S_IDLE;
        end else if (tick_q == READ_LAST) begin
          state_d = S_CHECK;
          bal_d   = card_bal;
        end
      end
      S_CHECK:  state_d = (bal_q >= FARE_B) ? S_SHOW : S_REJECT;
      S_SHOW:   if (tick_q == SHOW_LAST) state_d = S_OPEN;
      S_OPEN:   if (pass_sensor || (tick_q == OPEN_LAST)) state_d = S_IDLE;
      S_REJECT: if (tick_q == SHOW_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    tick_d = (state_d != state_q) ? '0 : tick_q + TICK_W'(1);

    arm_d = arm_q;
    if (!card_present) begin
      arm_d = 1'b1;
    end else if (state_q == S_CHECK) begin
      arm_d = 1'b0;
    end

    // The write-back is registered on the edge into CHECK so the strobe spans exactly that cycle.
    new_bal_d = new_bal_q;
    nbv_d     = 1'b0;
    if ((state_q == S_READ) && (state_d == S_CHECK) && (card_bal >= FARE_B)) begin
      new_bal_d = card_bal - FARE_B;
      nbv_d     = 1'b1;
    end

    case (state_d)
      S_IDLE:          begin disp_hi_d = 4'h8;     disp_lo_d = 4'hB;      end
      S_READ, S_CHECK: begin disp_hi_d = 4'h8;     disp_lo_d = 4'h8;      end
      S_SHOW:          begin disp_hi_d = rem_tens; disp_lo_d = rem_units; end
      S_OPEN:          begin disp_hi_d = 4'hF;     disp_lo_d = 4'h0;      end
      S_REJECT:        begin disp_hi_d = 4'hA;     disp_lo_d = 4'h0;      end
      default:         begin disp_hi_d = 4'h8;     disp_lo_d = 4'hB;      end
    endcase

    gate_d = (state_d == S_OPEN);

    cnt_d = cnt_q;
    if ((state_q == S_OPEN) && pass_sensor && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      arm_q     <= 1'b1;
      bal_q     <= '0;
      new_bal_q <= '0;
      nbv_q     <= 1'b0;
      disp_hi_q <= 4'h8;
      disp_lo_q <= 4'hB;
      gate_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      arm_q     <= arm_d;
      bal_q     <= bal_d;
      new_bal_q <= new_bal_d;
      nbv_q     <= nbv_d;
      disp_hi_q <= disp_hi_d;
      disp_lo_q <= disp_lo_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
    end
  end

  assign new_bal       = new_bal_q;
  assign new_bal_valid = nbv_q;
  assign disp_hi       = disp_hi_q;
  assign disp_lo       = disp_lo_q;
  assign gate_open     = gate_q;
  assign pass_count    = cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_turnstile_ctrl.sv
// Directed bench for turnstile_ctrl: cycle-level reference model plus literal checks,
// and a second small instance for passenger-counter saturation.

module tb_turnstile_ctrl;

  localparam int BAL_W      = 8;
  localparam int FARE       = 5;
  localparam int READ_TICKS = 400;
  localparam int SHOW_TICKS = 600;
  localparam int OPEN_TICKS = 800;
  localparam int CNT_W      = 16;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             card_present = 1'b0;
  logic [BAL_W-1:0] card_bal = '0;
  logic             pass_sensor = 1'b0;
  logic [BAL_W-1:0] new_bal;
  logic             new_bal_valid;
  logic [3:0]       disp_hi, disp_lo;
  logic             gate_open;
  logic [CNT_W-1:0] pass_count;
  logic [2:0]       state_dbg;

  logic             cp2 = 1'b0;
  logic [7:0]       bal2 = 8'd50;
  logic             ps2 = 1'b0;
  logic [7:0]       nb2;
  logic             nbv2;
  logic [3:0]       dh2, dl2;
  logic             go2;
  logic [1:0]       pc2;
  logic [2:0]       sd2;

  turnstile_ctrl #(
    .BAL_W(BAL_W), .FARE(FARE), .READ_TICKS(READ_TICKS),
    .SHOW_TICKS(SHOW_TICKS), .OPEN_TICKS(OPEN_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .card_present(card_present), .card_bal(card_bal),
    .pass_sensor(pass_sensor), .new_bal(new_bal), .new_bal_valid(new_bal_valid),
    .disp_hi(disp_hi), .disp_lo(disp_lo), .gate_open(gate_open),
    .pass_count(pass_count), .state_dbg(state_dbg)
  );

  turnstile_ctrl #(
    .BAL_W(8), .FARE(5), .READ_TICKS(2), .SHOW_TICKS(2), .OPEN_TICKS(3), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .card_present(cp2), .card_bal(bal2),
    .pass_sensor(ps2), .new_bal(nb2), .new_bal_valid(nbv2),
    .disp_hi(dh2), .disp_lo(dl2), .gate_open(go2),
    .pass_count(pc2), .state_dbg(sd2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase number, cycles already spent in it, and the facts the rules need.
  int m_st = 0, m_held = 0, m_bal = 0, m_last_nb = 0, m_count = 0;
  bit m_arm = 1'b1;

  always @(posedge clk or negedge reset) begin
    int nxt;
    if (!reset) begin
      m_st = 0; m_held = 0; m_bal = 0; m_last_nb = 0; m_count = 0; m_arm = 1'b1;
    end else begin
      nxt = m_st;
      case (m_st)
        0: if (card_present && m_arm) nxt = 1;
        1: begin
          if (!card_present) nxt = 0;
          else if (m_held + 1 == READ_TICKS) begin m_bal = int'(card_bal); nxt = 2; end
        end
        2: if (m_bal >= FARE) begin m_last_nb = m_bal - FARE; nxt = 3; end else nxt = 5;
        3: if (m_held + 1 == SHOW_TICKS) nxt = 4;
        4: begin
          if (pass_sensor) begin
            nxt = 0;
            if (m_count < CMAX) m_count = m_count + 1;
          end else if (m_held + 1 == OPEN_TICKS) nxt = 0;
        end
        5: if (m_held + 1 == SHOW_TICKS) nxt = 0;
        default: nxt = 0;
      endcase
      if (!card_present) m_arm = 1'b1;
      else if (m_st == 2) m_arm = 1'b0;
      m_held = (nxt == m_st) ? m_held + 1 : 0;
      m_st = nxt;
    end
  end

  always @(negedge clk) begin
    int e_hi, e_lo, e_nb, v;
    bit e_nbv;
    e_nbv = (m_st == 2) && (m_bal >= FARE);
    e_nb  = e_nbv ? m_bal - FARE : m_last_nb;
    case (m_st)
      1, 2: begin e_hi = 8; e_lo = 8; end
      3: begin
        v = m_bal - FARE;
        if (v > 99) v = 99;
        e_hi = v / 10; e_lo = v % 10;
      end
      4: begin e_hi = 15; e_lo = 0; end
      5: begin e_hi = 10; e_lo = 0; end
      default: begin e_hi = 8; e_lo = 11; end
    endcase
    n_cmp++;
    if ({state_dbg, gate_open, new_bal_valid, new_bal, disp_hi, disp_lo, pass_count} !==
        {3'(m_st), (m_st == 4), e_nbv, BAL_W'(e_nb), 4'(e_hi), 4'(e_lo), CNT_W'(m_count)}) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got st=%0d gate=%0b v=%0b nb=%0d disp=%0h/%0h cnt=%0d expected st=%0d gate=%0b v=%0b nb=%0d disp=%0h/%0h cnt=%0d",
               $time, state_dbg, gate_open, new_bal_valid, new_bal, disp_hi, disp_lo, pass_count,
               m_st, (m_st == 4), e_nbv, e_nb, e_hi, e_lo, m_count);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state_dbg) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(state_dbg) != code) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, state %0d expected %0d", name, state_dbg, code);
    end
  endtask

  task automatic dwell(input int code, output int n);
    n = 0;
    while (int'(state_dbg) == code && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_disp_hi", disp_hi, 8);
    check("rst_disp_lo", disp_lo, 11);
    check("rst_gate", gate_open, 0);
    check("rst_count", pass_count, 0);
    check("rst_strobe", new_bal_valid, 0);
    check("rst_new_bal", new_bal, 0);
    reset = 1'b1;

    // balance 12: full accepted passage
    card_bal = 8'd12; card_present = 1'b1;
    wait_state(1, 5, "s1_enter_read");
    dwell(1, n);
    check("s1_read_len", n, 400);
    check("s1_new_bal", new_bal, 7);
    check("s1_strobe", new_bal_valid, 1);
    card_present = 1'b0;
    @(negedge clk);
    check("s1_show_state", state_dbg, 3);
    check("s1_strobe_gone", new_bal_valid, 0);
    check("s1_disp_hi", disp_hi, 0);
    check("s1_disp_lo", disp_lo, 7);
    dwell(3, n);
    check("s1_show_len", n, 600);
    check("s1_gate", gate_open, 1);
    check("s1_open_hi", disp_hi, 15);
    check("s1_open_lo", disp_lo, 0);
    repeat (5) @(negedge clk);
    pass_sensor = 1'b1;
    @(negedge clk);
    pass_sensor = 1'b0;
    check("s1_idle", state_dbg, 0);
    check("s1_gate_closed", gate_open, 0);
    check("s1_count", pass_count, 1);

    // balance exactly the fare
    card_bal = 8'd5; card_present = 1'b1;
    wait_state(2, 500, "s2_check");
    check("s2_new_bal", new_bal, 0);
    check("s2_strobe", new_bal_valid, 1);
    card_present = 1'b0;
    wait_state(3, 5, "s2_show");
    check("s2_disp_hi", disp_hi, 0);
    check("s2_disp_lo", disp_lo, 0);
    wait_state(4, 700, "s2_open");
    check("s2_gate", gate_open, 1);
    pass_sensor = 1'b1;
    @(negedge clk);
    pass_sensor = 1'b0;
    check("s2_count", pass_count, 2);

    // balance one below the fare, card held through REJECT
    card_bal = 8'd4; card_present = 1'b1;
    wait_state(2, 500, "s3_check");
    check("s3_no_strobe", new_bal_valid, 0);
    check("s3_new_bal_held", new_bal, 0);
    @(negedge clk);
    check("s3_reject", state_dbg, 5);
    check("s3_disp_hi", disp_hi, 10);
    check("s3_disp_lo", disp_lo, 0);
    check("s3_gate", gate_open, 0);
    dwell(5, n);
    check("s3_reject_len", n, 600);
    check("s3_idle", state_dbg, 0);
    repeat (50) @(negedge clk);
    check("s3_no_rearm", state_dbg, 0);
    card_present = 1'b0;
    @(negedge clk);

    // large balance, display clamps, then OPEN timeout
    card_bal = 8'd200; card_present = 1'b1;
    wait_state(2, 500, "s4_check");
    check("s4_new_bal", new_bal, 195);
    check("s4_strobe", new_bal_valid, 1);
    card_present = 1'b0;
    wait_state(3, 5, "s4_show");
    check("s4_disp_hi", disp_hi, 9);
    check("s4_disp_lo", disp_lo, 9);
    wait_state(4, 700, "s4_open");
    dwell(4, n);
    check("s4_open_len", n, 800);
    check("s4_gate_closed", gate_open, 0);
    check("s4_count", pass_count, 2);

    // card removed during READ cycle 399, then during the last READ cycle
    card_bal = 8'd12; card_present = 1'b1;
    wait_state(1, 5, "s5_read");
    repeat (398) @(negedge clk);
    card_present = 1'b0;
    @(negedge clk);
    check("s5_abort_399", state_dbg, 0);
    check("s5_no_strobe", new_bal_valid, 0);
    card_present = 1'b1;
    wait_state(1, 5, "s5b_read");
    repeat (399) @(negedge clk);
    card_present = 1'b0;
    @(negedge clk);
    check("s5_abort_400", state_dbg, 0);

    // passage on the final OPEN cycle wins over the timeout
    card_present = 1'b1;
    wait_state(2, 500, "s6_check");
    card_present = 1'b0;
    wait_state(4, 700, "s6_open");
    repeat (799) @(negedge clk);
    check("s6_still_open", state_dbg, 4);
    pass_sensor = 1'b1;
    @(negedge clk);
    pass_sensor = 1'b0;
    check("s6_count", pass_count, 3);
    check("s6_idle", state_dbg, 0);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      cp2 = 1'b1;
      n = 0;
      while (!go2 && n < 30) begin @(negedge clk); n++; end
      if (!go2) begin
        n_cmp++; n_err++;
        $display("FAIL sat_gate_%0d: timeout, gate %0b expected 1", i, go2);
      end
      cp2 = 1'b0; ps2 = 1'b1;
      @(negedge clk);
      ps2 = 1'b0;
      check($sformatf("sat_count_%0d", i), pc2, (i < 3) ? i + 1 : 3);
    end

    // asynchronous reset in OPEN
    card_bal = 8'd12; card_present = 1'b1;
    wait_state(2, 500, "s7_check");
    card_present = 1'b0;
    wait_state(4, 700, "s7_open");
    repeat (3) @(negedge clk);
    check("s7_gate_before", gate_open, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("s7_gate_async", gate_open, 0);
    check("s7_hi_async", disp_hi, 8);
    check("s7_lo_async", disp_lo, 11);
    check("s7_state_async", state_dbg, 0);
    check("s7_count_async", pass_count, 0);
    @(negedge clk);
    card_present = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("s7_first_edge", state_dbg, 1);
    card_present = 1'b0;
    @(negedge clk);
    check("s7_back_idle", state_dbg, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/turnstile_ctrl.md
TURNSTILE_CTRL -- requirements
Module: turnstile_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- BAL_W, 8, card balance width in bits.
- FARE, 5, fare deducted per passage; legal range 1..2^BAL_W-1.
- READ_TICKS, 400, cycles card_present must stay high before a read is accepted; minimum 1.
- SHOW_TICKS, 600, cycles the balance or reject code is displayed; minimum 1.
- OPEN_TICKS, 800, maximum cycles the gate stays open; minimum 1.
- CNT_W, 16, passenger counter width.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-low.
- card_present, in, 1, card on reader.
- card_bal, in, BAL_W, card balance; unsigned.
- pass_sensor, in, 1, passenger through gate.
- new_bal, out, BAL_W, balance to write back to the card.
- new_bal_valid, out, 1, one-cycle write-back strobe.
- disp_hi, out, 4, display digit or code, high position.
- disp_lo, out, 4, display digit or code, low position.
- gate_open, out, 1, gate release.
- pass_count, out, CNT_W, saturating count of accepted passages.
- state_dbg, out, 3, current state encoding.

Function
REQ-003 The state machine SHALL have states IDLE=0, READ=1, CHECK=2, SHOW=3, OPEN=4, REJECT=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-004 One shared tick counter SHALL clear on every state entry and increment each cycle the state is held.
REQ-005 IDLE SHALL go to READ only when card_present is high and a re-arm flag is set. The flag clears on leaving CHECK and sets on any cycle card_present is low.
REQ-006 READ SHALL return to IDLE on any cycle card_present is low. After READ_TICKS consecutive high cycles it SHALL latch card_bal and go to CHECK.
REQ-007 CHECK SHALL last one cycle:
- If latched balance >= FARE: drive new_bal = balance-FARE, pulse new_bal_valid for exactly that cycle, latch the remainder, and go to SHOW.
- Otherwise: go to REJECT with new_bal_valid low.
REQ-008 The remainder display SHALL be two BCD digits: disp_hi = tens, disp_lo = units. Remainders above 99 SHALL display 9/9.
REQ-009 SHOW SHALL hold for SHOW_TICKS cycles and then go to OPEN.
REQ-010 REJECT SHALL display A/0 for SHOW_TICKS cycles and then go to IDLE.
REQ-011 OPEN SHALL drive gate_open=1 and display F/0.
- If pass_sensor is high, go to IDLE and increment pass_count.
- Otherwise, after OPEN_TICKS cycles, go to IDLE without counting.
- If pass_sensor is high on the timeout cycle, the pass SHALL win and be counted.
REQ-012 pass_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-013 Display SHALL be IDLE 8/B, READ and CHECK 8/8.
REQ-014 gate_open SHALL be 1 only in OPEN.
REQ-015 new_bal SHALL hold its last value outside CHECK.
REQ-016 All outputs SHALL be registered and update on the same edge as the state transition they reflect.
REQ-017 Arithmetic: the subtraction SHALL be BAL_W bits and is never performed when it would underflow. The BCD conversion SHALL be on the clamped value 0..99.
REQ-018 card_bal changes outside the latch cycle SHALL have no effect.

Reset
REQ-019 On reset low, asynchronously and independent of clk:
- state=IDLE, tick counter=0, re-arm flag=1.
- new_bal=0, new_bal_valid=0, gate_open=0, pass_count=0.
- disp_hi=8, disp_lo=B.
REQ-020 Reset asserted mid-operation, including in OPEN, SHALL close the gate immediately and discard the latched balance.
REQ-021 After reset release, the first transition SHALL occur on the first rising clk edge with reset high.

Verification
REQ-022 The bench SHALL cover these directed scenarios (default parameters):
- card_bal=12, card_present high 400 cycles -> CHECK with new_bal=7 and one-cycle new_bal_valid; SHOW 0/7 for 600 cycles; OPEN F/0 with gate_open=1; pass_sensor high -> IDLE, pass_count=1.
- card_bal=5 -> new_bal=0, display 0/0, gate opens. card_bal=4 -> REJECT A/0 for 600 cycles, no strobe, gate stays closed, then IDLE.
- card_present drops at cycle 399 of READ -> back to IDLE, no strobe. Card held high through REJECT -> no new read until card_present goes low and high again.
- OPEN with no pass_sensor -> gate closes after 800 cycles, pass_count unchanged. pass_sensor high on cycle 800 -> counted.
- card_bal=200 -> new_bal=195, display 9/9.
- Set CNT_W=2 and complete 5 passages -> pass_count=3.
- Reset pulsed low mid-OPEN without clk -> gate_open=0 and display 8/B immediately.
